// File: rtl/downcounter_pkg.sv
// Shared definitions for the loadable down-counter/timer: default width and
// the two-state run/idle encoding.
package downcounter_pkg;

    localparam int unsigned DC_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dc_state_e;

endpackage

// File: rtl/downcounter_dec.sv
// Combinational decrementer DIFF = A - 1 built as a half-subtractor borrow
// chain; the structural mirror of the up-counter's incrementer.
module downcounter_dec
    import downcounter_pkg::*;
#(
    parameter int unsigned WIDTH = DC_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] diff
);

    logic [WIDTH-1:0] borrow;

    // Subtracting one: a borrow enters bit 0 and ripples upward through zeros.
    always_comb begin
        borrow    = '0;
        borrow[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            borrow[i] = borrow[i-1] & ~a[i-1];
        end
        diff = a ^ borrow;
    end

endmodule

// File: rtl/downcounter_timer.sv
// Loadable down-counter/timer: counts a loaded value to zero under enable,
// pulses tc for one cycle at terminal count and optionally auto-reloads.
module downcounter_timer
    import downcounter_pkg::*;
#(
    parameter int unsigned WIDTH = DC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    dc_state_e        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] count_dec;

    downcounter_dec #(
        .WIDTH(WIDTH)
    ) u_dec (
        .a    (count_q),
        .diff (count_dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        busy_d   = busy_q;

        if (load) begin
            // A zero load parks the timer in IDLE so no tc can ever follow it.
            count_d  = load_val;
            reload_d = load_val;
            if (load_val != '0) begin
                state_d = RUN;
                busy_d  = 1'b1;
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (en) begin
                        if (count_q == WIDTH'(1)) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end else if (count_q != '0) begin
                            count_d = count_dec;
                        end else begin
                            // Never decrement from zero; fall back to IDLE.
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;

endmodule

// File: doc/downcounter_timer.md
Name: downcounter_timer

Overview:
- Loadable 8-bit down-counter and timer; counterpart to the free-running up-counter in the counter/ALU subsystem.
- Counts a loaded value down to zero under an enable.
- Emits a one-cycle terminal-count pulse at zero, with optional auto-reload for periodic ticks.
- Used by the ALU-side control logic as a programmable delay and tick generator.

Parameters:
WIDTH, 8, width of the count, load value and reload register

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-high
load  input  1  load request; samples load_val this cycle
load_val  input  WIDTH  start value (also captured as the reload value)
en  input  1  count enable; one decrement per enabled cycle while running
auto_reload  input  1  at terminal count, restart from the reload value instead of stopping
count  output  WIDTH  current count value (registered)
tc  output  1  terminal-count pulse, exactly one cycle wide (registered)
busy  output  1  high while in RUN (registered)

Behaviour:
- Reset is asynchronous and active-high. On reset assertion, immediately:
  - count=0, reload_reg=0, tc=0, busy=0, state=IDLE.
  - Outputs stay at these values while reset is held.
- States:
  - IDLE: count held; en ignored.
  - RUN: decrement on en.
- Priority each cycle: reset > load > terminal decrement > normal decrement > hold.
- load=1, in any state:
  - count<=load_val and reload_reg<=load_val; tc<=0.
  - If load_val!=0: state<=RUN, busy<=1. If load_val==0: state<=IDLE, busy<=0, no tc ever generated.
  - en is ignored in the load cycle.
- RUN, en=1, count>1: count<=count-1; tc<=0.
- RUN, en=1, count==1 (terminal decrement):
  - tc<=1 for the next cycle only.
  - auto_reload=0: count<=0, state<=IDLE, busy<=0.
  - auto_reload=1: count<=reload_reg, state stays RUN, busy stays 1. The reload value is never 0 here, because RUN is only entered with a nonzero value.
- RUN, en=0: count, state and busy hold; tc<=0.
- Timing: N consecutive enabled cycles after a load of N>0 produce tc on the clock edge after the Nth enable. That is, tc is high in the cycle where count first reads 0 (non-reload) or first reads reload_reg again (reload).
- count never wraps below 0. No decrement is performed from 0.
- load asserted in the same cycle as a terminal decrement: load wins and no tc is produced.
- auto_reload is sampled only at the terminal decrement. Changing it mid-count has no other effect.
- Reset asserted mid-count: immediate return to the reset values. Any pending tc is discarded.
- Arithmetic: unsigned, WIDTH bits. The maximum load is 2^WIDTH-1 (255), which gives 255 enabled cycles to tc.

Decomposition:
- Shared package downcounter_pkg: WIDTH default; state encoding constants (IDLE=1'b0, RUN=1'b1).
- One combinational sub-module, downcounter_dec (A[WIDTH-1:0] -> DIFF = A-1, half-subtractor borrow chain). It is the structural mirror of the existing incrementer and can be mapped onto the same cell library.
- The top level holds the state, count and reload registers and the tc/busy flops.

Test Plan:
1. Reset check: assert reset asynchronously mid-cycle -> count=0, tc=0, busy=0 immediately, before the next clk edge. Release, en=1 with no load -> count stays 0, no tc.
2. One-shot: load_val=5 with load, then en=1 continuously, auto_reload=0 -> count 5,4,3,2,1,0. tc=1 only in the cycle count=0; busy falls the same cycle; count stays 0 thereafter.
3. Auto-reload: load_val=3, auto_reload=1, en=1 continuously -> count 3,2,1,3,2,1,... with tc high each time count returns to 3 (every 3 cycles); busy stays 1.
4. Enable gating: load_val=4, en pattern 1,0,0,1,1,0,1 -> count 4,3,3,3,2,1,1,0. tc is asserted once, at the transition to 0.
5. Collisions: load_val=2, decrement to count=1, then assert load with load_val=7 and en=1 in the same cycle -> count=7, tc=0, busy=1. Separately, load_val=0 -> count=0, busy=0, no tc.
6. Reset mid-operation and boundary: load_val=255, en=1 for 100 cycles, then pulse reset -> all outputs at reset values. Reload 255 and run 255 enabled cycles -> a single tc on the 255th edge, and count is never observed above 255 or wrapping.
